// File: rtl/max7219_pkg.sv
`timescale 1ns/1ps
// max7219_pkg: register addresses, word field layout, FSM state type and the
// per-matrix register image shared by the MAX7219 frame receiver.
package max7219_pkg;

    // MAX7219 register addresses (word bits [11:8])
    localparam logic [3:0] C_MAX7219_ADDR_NOOP       = 4'h0;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] C_MAX7219_ADDR_DECODE     = 4'h9;
    localparam logic [3:0] C_MAX7219_ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] C_MAX7219_ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] C_MAX7219_ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] C_MAX7219_ADDR_TEST       = 4'hF;

    // 16-bit command word layout: [15:12] don't care, [11:8] address, [7:0] data
    localparam int C_WORD_BITS = 16;
    localparam int C_ADDR_LSB  = 8;
    localparam int C_ADDR_BITS = 4;
    localparam int C_DATA_LSB  = 0;
    localparam int C_DATA_BITS = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } t_rx_state;

    // Register image of one MAX7219; narrow fields hold only their defined bits.
    typedef struct packed {
        logic [7:0][7:0] digit;
        logic [7:0]      decode;
        logic [3:0]      intensity;
        logic [2:0]      scan_limit;
        logic            shutdown;
        logic            test;
    } t_matrix_regs;

    // Apply one decoded command word to a matrix image.
    function automatic t_matrix_regs apply_word(input t_matrix_regs regs,
                                                input logic [3:0]   addr,
                                                input logic [7:0]   data);
        t_matrix_regs upd;
        upd = regs;
        case (addr)
            C_MAX7219_ADDR_DIGIT0, C_MAX7219_ADDR_DIGIT1,
            C_MAX7219_ADDR_DIGIT2, C_MAX7219_ADDR_DIGIT3,
            C_MAX7219_ADDR_DIGIT4, C_MAX7219_ADDR_DIGIT5,
            C_MAX7219_ADDR_DIGIT6, C_MAX7219_ADDR_DIGIT7:
                upd.digit[3'(addr - C_MAX7219_ADDR_DIGIT0)] = data;
            C_MAX7219_ADDR_DECODE:     upd.decode     = data;
            C_MAX7219_ADDR_INTENSITY:  upd.intensity  = data[3:0];
            C_MAX7219_ADDR_SCAN_LIMIT: upd.scan_limit = data[2:0];
            C_MAX7219_ADDR_SHUTDOWN:   upd.shutdown   = data[0];
            C_MAX7219_ADDR_TEST:       upd.test       = data[0];
            C_MAX7219_ADDR_NOOP:       ;
            default:                   ;  // 0xD and 0xE are ignored
        endcase
        return upd;
    endfunction

    // Read back one register of a matrix image, narrow fields zero-extended.
    function automatic logic [7:0] read_reg(input t_matrix_regs regs,
                                            input logic [3:0]   addr);
        logic [7:0] val;
        val = 8'h00;
        case (addr)
            C_MAX7219_ADDR_DIGIT0, C_MAX7219_ADDR_DIGIT1,
            C_MAX7219_ADDR_DIGIT2, C_MAX7219_ADDR_DIGIT3,
            C_MAX7219_ADDR_DIGIT4, C_MAX7219_ADDR_DIGIT5,
            C_MAX7219_ADDR_DIGIT6, C_MAX7219_ADDR_DIGIT7:
                val = regs.digit[3'(addr - C_MAX7219_ADDR_DIGIT0)];
            C_MAX7219_ADDR_DECODE:     val = regs.decode;
            C_MAX7219_ADDR_INTENSITY:  val = {4'h0, regs.intensity};
            C_MAX7219_ADDR_SCAN_LIMIT: val = {5'h00, regs.scan_limit};
            C_MAX7219_ADDR_SHUTDOWN:   val = {7'h00, regs.shutdown};
            C_MAX7219_ADDR_TEST:       val = {7'h00, regs.test};
            default:                   val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/max7219_frame_receiver_if.sv
`timescale 1ns/1ps
// max7219_frame_receiver_if: MAX7219 pin bundle, register read port and
// frame status flags of the frame receiver.
interface max7219_frame_receiver_if #(
    parameter int G_BIT_CNT_WIDTH = 8
);
    logic                       i_max7219_clk;
    logic                       i_max7219_din;
    logic                       i_max7219_load;
    logic [3:0]                 i_rd_matrix;
    logic [3:0]                 i_rd_addr;
    logic [7:0]                 o_rd_data;
    logic                       o_frame_valid;
    logic                       o_frame_error;
    logic                       o_overrun;
    logic                       o_busy;
    logic [G_BIT_CNT_WIDTH-1:0] o_bit_cnt;

    // Display controller / reader side
    modport master (
        output i_max7219_clk, i_max7219_din, i_max7219_load,
        output i_rd_matrix, i_rd_addr,
        input  o_rd_data, o_frame_valid, o_frame_error, o_overrun, o_busy, o_bit_cnt
    );

    // Receiver side
    modport slave (
        input  i_max7219_clk, i_max7219_din, i_max7219_load,
        input  i_rd_matrix, i_rd_addr,
        output o_rd_data, o_frame_valid, o_frame_error, o_overrun, o_busy, o_bit_cnt
    );
endinterface

// File: rtl/max7219_sync_edge.sv
`timescale 1ns/1ps
// max7219_sync_edge: 2-FF synchronizer for one asynchronous pin followed by a
// registered output. With G_RISE=1 the output is a one-cycle rising-edge
// strobe; with G_RISE=0 it is the synchronized level delayed to the same
// latency, so data sampled with it lines up with a sibling strobe.
// Pin change to output takes 3 clk.
module max7219_sync_edge #(
    parameter bit G_RISE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic strobe
);
    logic meta;
    logic sync;
    logic sync_d;

    // Synchronizer chain plus one history flop for edge detection.
    // NOTE: non-blocking assignments make every flop take its neighbour's pre-edge value, so this is a true 3-stage pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // Registered output: rising-edge strobe or delayed level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe <= 1'b0;
        end else if (G_RISE) begin
            strobe <= sync & ~sync_d;
        end else begin
            strobe <= sync;
        end
    end
endmodule

// File: rtl/max7219_frame_receiver.sv
`timescale 1ns/1ps
// max7219_frame_receiver: receive end of a daisy-chained MAX7219 link.
// Deserializes CLK/DIN, and on each LOAD rising edge checks the bit count,
// snapshots the frame and writes one matrix image per clock. The register
// image is readable through a registered read port.
module max7219_frame_receiver
    import max7219_pkg::*;
#(
    parameter int G_NB_MATRIX     = 8,
    parameter int G_BIT_CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    max7219_frame_receiver_if.slave bus
);
    localparam int                         C_FRAME_BITS = C_WORD_BITS * G_NB_MATRIX;
    localparam logic [G_BIT_CNT_WIDTH-1:0] C_FRAME_CNT  = G_BIT_CNT_WIDTH'(C_FRAME_BITS);
    localparam logic [3:0]                 C_LAST_IDX   = 4'(G_NB_MATRIX - 1);

    // Synchronized pin events
    logic clk_re;
    logic din_s;
    logic load_re;

    // Deserializer and frame capture
    logic [C_FRAME_BITS-1:0]    shift_reg;
    logic [C_FRAME_BITS-1:0]    shift_eff;
    logic [C_FRAME_BITS-1:0]    snapshot;
    logic [G_BIT_CNT_WIDTH-1:0] bit_cnt;
    logic [G_BIT_CNT_WIDTH-1:0] cnt_eff;
    logic                       frame_ok;

    // FSM
    t_rx_state  state;
    t_rx_state  state_next;
    logic [3:0] mat_idx;
    logic       busy;
    logic       start_update;
    logic       flag_error;
    logic       flag_overrun;
    logic       last_write;

    // Register image (16 slots so the 4-bit read index is always in range)
    t_matrix_regs image [16];
    logic [3:0]   cur_addr;
    logic [7:0]   cur_data;

    // Registered outputs
    logic [7:0] rd_data;
    logic       frame_valid;
    logic       frame_error;
    logic       overrun;

    max7219_sync_edge #(.G_RISE(1'b1)) u_sync_clk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.i_max7219_clk),
        .strobe   (clk_re)
    );

    max7219_sync_edge #(.G_RISE(1'b0)) u_sync_din (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.i_max7219_din),
        .strobe   (din_s)
    );

    max7219_sync_edge #(.G_RISE(1'b1)) u_sync_load (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.i_max7219_load),
        .strobe   (load_re)
    );

    // Shift register and bit count as seen this cycle, including a bit that
    // arrives together with LOAD so the count check sees it.
    always_comb begin
        shift_eff = shift_reg;
        cnt_eff   = bit_cnt;
        if (clk_re) begin
            shift_eff = {shift_reg[C_FRAME_BITS-2:0], din_s};
            cnt_eff   = (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
        end
        frame_ok = (cnt_eff == C_FRAME_CNT);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (load_re && frame_ok) state_next = S_UPDATE;
            S_UPDATE: if (mat_idx == C_LAST_IDX) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag, capture/write controls and pulse conditions.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        busy         = 1'b0;
        start_update = 1'b0;
        flag_error   = 1'b0;
        flag_overrun = 1'b0;
        last_write   = 1'b0;
        case (state)
            S_IDLE: begin
                start_update = load_re && frame_ok;
                flag_error   = load_re && !frame_ok;
            end
            S_UPDATE: begin
                busy         = 1'b1;
                flag_overrun = load_re;
                last_write   = (mat_idx == C_LAST_IDX);
            end
            default: ;
        endcase
    end

    // Deserializer, bit counter, frame snapshot, matrix index and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            snapshot    <= '0;
            mat_idx     <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            shift_reg   <= shift_eff;
            bit_cnt     <= load_re ? '0 : cnt_eff;
            frame_valid <= last_write;
            frame_error <= flag_error;
            overrun     <= flag_overrun;
            if (start_update) begin
                snapshot <= shift_eff;
                mat_idx  <= '0;
            end else if (busy) begin
                mat_idx  <= mat_idx + 4'd1;
            end
        end
    end

    // Word for the matrix being written this cycle.
    always_comb begin
        cur_addr = snapshot[C_WORD_BITS*int'(mat_idx) + C_ADDR_LSB +: C_ADDR_BITS];
        cur_data = snapshot[C_WORD_BITS*int'(mat_idx) + C_DATA_LSB +: C_DATA_BITS];
    end

    // Register image update, one matrix per UPDATE cycle.
    // NOTE: the image is a flop array rather than a RAM so that reset can clear it; do not map it to block memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            image <= '{default: '0};
        end else if (busy) begin
            image[mat_idx] <= apply_word(image[mat_idx], cur_addr, cur_data);
        end
    end

    // Registered read port; matrices beyond the chain read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (int'(bus.i_rd_matrix) < G_NB_MATRIX) begin
            rd_data <= read_reg(image[bus.i_rd_matrix], bus.i_rd_addr);
        end else begin
            rd_data <= 8'h00;
        end
    end

    assign bus.o_rd_data     = rd_data;
    assign bus.o_frame_valid = frame_valid;
    assign bus.o_frame_error = frame_error;
    assign bus.o_overrun     = overrun;
    assign bus.o_busy        = busy;
    assign bus.o_bit_cnt     = bit_cnt;

endmodule

// File: tb/tb_max7219_frame_receiver.sv
`timescale 1ns/1ps
// tb_max7219_frame_receiver: directed bench for the MAX7219 frame receiver.
// Frame events are predicted into a queue and matched by a monitor; the
// register image is compared against a bench-side model of the MAX7219.
module tb_max7219_frame_receiver;
    localparam int N = 8;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    max7219_frame_receiver_if #(.G_BIT_CNT_WIDTH(W)) bus ();

    max7219_frame_receiver #(
        .G_NB_MATRIX     (N),
        .G_BIT_CNT_WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  exp_q [$];          // expected events {valid, error, overrun}
    logic [2:0]  mon_ev;
    logic [7:0]  model [N][16];      // expected read value per matrix/address
    logic [15:0] words [N];          // frame under construction, index = matrix
    bit          mon_en = 1'b0;
    int          lat;
    int          busy_n;

    localparam logic [2:0] EV_VALID   = 3'b100;
    localparam logic [2:0] EV_ERROR   = 3'b010;
    localparam logic [2:0] EV_OVERRUN = 3'b001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: every status pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (mon_en && (bus.o_frame_valid || bus.o_frame_error || bus.o_overrun)) begin
            mon_ev = {bus.o_frame_valid, bus.o_frame_error, bus.o_overrun};
            if (exp_q.size() == 0) check("unexpected_event", {29'd0, mon_ev}, 32'd0);
            else                   check("event", {29'd0, mon_ev}, {29'd0, exp_q.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.i_max7219_din = b;
        tick(3);
        bus.i_max7219_clk = 1'b1;
        tick(3);
        bus.i_max7219_clk = 1'b0;
    endtask

    // Sends the first nbits of the frame, farthest matrix first, MSB first.
    task automatic send_frame_bits(input int nbits);
        int sent = 0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int b = 15; b >= 0; b--) begin
                if (sent < nbits) begin
                    send_bit(words[k][b]);
                    sent++;
                end
            end
        end
        tick(4);
    endtask

    task automatic send_random_bits(input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
        tick(4);
    endtask

    task automatic pulse_load(input int hold);
        bus.i_max7219_load = 1'b1;
        tick(hold);
        bus.i_max7219_load = 1'b0;
    endtask

    // Raises LOAD and measures clk cycles until o_frame_valid, counting busy cycles.
    task automatic load_and_time(output int latency, output int busy_cycles);
        latency = -1;
        busy_cycles = 0;
        bus.i_max7219_load = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 4) bus.i_max7219_load = 1'b0;
            if (bus.o_busy) busy_cycles++;
            if (bus.o_frame_valid) begin
                latency = i;
                break;
            end
        end
        bus.i_max7219_load = 1'b0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 16; a++) model[k][a] = 8'h00;
    endtask

    // Reference MAX7219 register semantics, written from the datasheet map.
    task automatic model_apply_frame();
        logic [3:0] a;
        logic [7:0] d;
        for (int k = 0; k < N; k++) begin
            a = words[k][11:8];
            d = words[k][7:0];
            case (a)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: model[k][a] = d;
                4'hA: model[k][a] = {4'h0, d[3:0]};
                4'hB: model[k][a] = {5'h00, d[2:0]};
                4'hC, 4'hF: model[k][a] = {7'h00, d[0]};
                default: ;
            endcase
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic read_all(input string tag);
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 16; a++) begin
                bus.i_rd_matrix = 4'(k);
                bus.i_rd_addr   = 4'(a);
                tick(1);
                check($sformatf("%s_m%0d_a%0h", tag, k, a), bus.o_rd_data, model[k][a]);
            end
        end
    endtask

    initial begin
        bus.i_max7219_clk  = 1'b0;
        bus.i_max7219_din  = 1'b0;
        bus.i_max7219_load = 1'b0;
        bus.i_rd_matrix    = 4'h0;
        bus.i_rd_addr      = 4'h0;
        model_clear();

        // Reset state
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(2);
        mon_en = 1'b1;
        check("reset_frame_valid", bus.o_frame_valid, 0);
        check("reset_frame_error", bus.o_frame_error, 0);
        check("reset_overrun", bus.o_overrun, 0);
        check("reset_busy", bus.o_busy, 0);
        check("reset_bit_cnt", bus.o_bit_cnt, 0);
        read_all("reset");
        bus.i_rd_matrix = 4'hF;
        bus.i_rd_addr   = 4'hA;
        tick(1);
        check("out_of_range_matrix", bus.o_rd_data, 0);

        // Full frame, intensity 5 everywhere, with latency measurement
        for (int k = 0; k < N; k++) words[k] = 16'h0A05;
        exp_q.push_back(EV_VALID);
        send_frame_bits(16 * N);
        check("bit_cnt_full", bus.o_bit_cnt, 16 * N);
        load_and_time(lat, busy_n);
        check("valid_latency_from_pin", lat, 12);
        check("busy_cycles", busy_n, N);
        model_apply_frame();
        wait_drain("drain_intensity");
        check("bit_cnt_cleared", bus.o_bit_cnt, 0);
        read_all("intensity");

        // Digits at both ends of the chain, no-ops elsewhere
        for (int k = 0; k < N; k++) words[k] = 16'h0000;
        words[0] = 16'h0181;
        words[N-1] = 16'h08FF;
        exp_q.push_back(EV_VALID);
        send_frame_bits(16 * N);
        pulse_load(3);
        model_apply_frame();
        wait_drain("drain_digits");
        read_all("digits");

        // Narrow fields, ignored addresses and don't-care upper nibble
        words[0] = 16'hFAFF;
        words[1] = 16'h0BFF;
        words[2] = 16'h0CFF;
        words[3] = 16'h0FFF;
        words[4] = 16'h0DFF;
        words[5] = 16'h09AB;
        words[6] = 16'h0E55;
        words[7] = 16'h0A10;
        exp_q.push_back(EV_VALID);
        send_frame_bits(16 * N);
        pulse_load(3);
        model_apply_frame();
        wait_drain("drain_fields");
        read_all("fields");

        // Short frame (127 bits) then long frame (129 bits)
        exp_q.push_back(EV_ERROR);
        send_random_bits(16 * N - 1);
        check("bit_cnt_127", bus.o_bit_cnt, 16 * N - 1);
        pulse_load(3);
        wait_drain("drain_err127");
        check("bit_cnt_after_err127", bus.o_bit_cnt, 0);
        read_all("after_err127");
        exp_q.push_back(EV_ERROR);
        send_random_bits(16 * N + 1);
        check("bit_cnt_129", bus.o_bit_cnt, 16 * N + 1);
        pulse_load(3);
        wait_drain("drain_err129");

        // Counter saturation
        exp_q.push_back(EV_ERROR);
        send_random_bits(260);
        check("bit_cnt_saturated", bus.o_bit_cnt, 255);
        pulse_load(3);
        wait_drain("drain_err_sat");
        check("bit_cnt_after_sat", bus.o_bit_cnt, 0);

        // Second LOAD edge 2 clk after a valid one: overrun, then the frame completes
        for (int k = 0; k < N; k++) words[k] = {4'h0, 4'(k + 1), 8'(k * 17 + 3)};
        exp_q.push_back(EV_OVERRUN);
        exp_q.push_back(EV_VALID);
        send_frame_bits(16 * N);
        bus.i_max7219_load = 1'b1;
        tick(1);
        bus.i_max7219_load = 1'b0;
        tick(1);
        bus.i_max7219_load = 1'b1;
        tick(1);
        bus.i_max7219_load = 1'b0;
        model_apply_frame();
        wait_drain("drain_overrun");
        check("bit_cnt_after_overrun", bus.o_bit_cnt, 0);
        read_all("overrun");

        // Reset during UPDATE: image cleared, no frame_valid
        for (int k = 0; k < N; k++) words[k] = 16'h0C01;
        send_frame_bits(16 * N);
        pulse_load(2);
        for (int i = 0; i < 20 && !bus.o_busy; i++) tick(1);
        check("busy_before_reset", bus.o_busy, 1);
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_clear();
        tick(12);
        check("busy_after_reset", bus.o_busy, 0);
        check("bit_cnt_after_reset", bus.o_bit_cnt, 0);
        read_all("after_reset");

        // Next frame, last DIN bit and LOAD rising together
        for (int k = 0; k < N; k++) words[k] = 16'h0A03;
        words[3] = 16'h0307;
        exp_q.push_back(EV_VALID);
        send_frame_bits(16 * N - 1);
        bus.i_max7219_din = words[0][0];
        tick(3);
        bus.i_max7219_clk  = 1'b1;
        bus.i_max7219_load = 1'b1;
        tick(3);
        bus.i_max7219_clk  = 1'b0;
        bus.i_max7219_load = 1'b0;
        model_apply_frame();
        wait_drain("drain_simultaneous");
        read_all("simultaneous");

        tick(5);
        check("no_pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
